// File: rtl/neuron_spike_pkg.sv
// neuron_spike_pkg
// Shared constants for the spike output FIFO: register offsets inside the
// 512-byte Wishbone window, CTRL bit indices, STATUS bit positions, the CTRL
// command struct and a STATUS packing helper.
package neuron_spike_pkg;

    // Register offsets (byte offset within the window)
    localparam logic [8:0] DATA_OFS   = 9'h000;
    localparam logic [8:0] STATUS_OFS = 9'h100;
    localparam logic [8:0] CTRL_OFS   = 9'h104;

    // CTRL bit indices
    localparam int unsigned POP_BIT     = 0;
    localparam int unsigned CLR_OVF_BIT = 1;
    localparam int unsigned FLUSH_BIT   = 2;

    // STATUS bit positions
    localparam int unsigned ST_COUNT_LSB = 0;
    localparam int unsigned ST_EMPTY_BIT = 8;
    localparam int unsigned ST_FULL_BIT  = 9;
    localparam int unsigned ST_OVF_BIT   = 10;
    localparam int unsigned ST_DROP_LSB  = 16;
    localparam int unsigned ST_IRQ_BIT   = 31;

    // Decoded CTRL write, one bit per single-shot action
    typedef struct packed {
        logic flush;
        logic clr_ovf;
        logic pop;
    } ctrl_cmd_t;

    function automatic logic [31:0] pack_status(
        input logic [7:0] count,
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [7:0] drop_cnt,
        input logic       irq
    );
        logic [31:0] s;
        s = '0;
        s[ST_COUNT_LSB +: 8] = count;
        s[ST_EMPTY_BIT]      = empty;
        s[ST_FULL_BIT]       = full;
        s[ST_OVF_BIT]        = ovf;
        s[ST_DROP_LSB +: 8]  = drop_cnt;
        s[ST_IRQ_BIT]        = irq;
        return s;
    endfunction

endpackage

// File: rtl/spike_vec_fifo.sv
// spike_vec_fifo
// Circular buffer of DEPTH whole spike vectors (WIDTH bits each).
// Priority: flush > push/pop. A push while full only lands if a pop happens
// in the same cycle; a pop while empty is ignored.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i         write wdata_i at the tail
//   pop_i          discard the head entry
//   flush_i        empty the FIFO, discarding any same-cycle push/pop
//   wdata_i        vector to push
//   head_o         head vector (combinational, undefined when empty)
//   count_o        occupancy 0..DEPTH
//   empty_o/full_o occupancy flags
//   drop_o         push rejected this cycle because the FIFO is full
module spike_vec_fifo
    import neuron_spike_pkg::*;
#(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic [7:0]       count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
    localparam logic [7:0]      DepthCnt = 8'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [7:0]       count_q, count_d;
    logic             do_push, do_pop, mem_we;

    function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        empty_o = (count_q == 8'd0);
        full_o  = (count_q == DepthCnt);
        do_pop  = pop_i & ~empty_o;
        // A pop frees a slot in the same cycle, so push-while-full still lands
        do_push = push_i & (~full_o | do_pop);
        // Full implies non-empty, so any pop request here is effective
        drop_o  = push_i & full_o & ~pop_i & ~flush_i;
        mem_we  = do_push & ~flush_i;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = inc_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = inc_ptr(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 8'd1;
                2'b01:   count_d = count_q - 8'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; it is only visible through the head when non-empty
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/neuron_spike_out_fifo.sv
// neuron_spike_out_fifo
// Buffers DEPTH spike vectors (NUM_WORDS x 32 bits) pushed by the core and
// exposes them to the host over a Wishbone slave window at BASE_ADDR:
//   0x000.. DATA   head vector word off[7:2] (0 when empty)
//   0x100   STATUS count, empty, full, sticky overflow, drop_cnt, [irq]
//   0x104   CTRL   write-only: bit0 POP, bit1 CLR_OVF, bit2 FLUSH (sel[0] gated)
// Optional feature macro SPIKE_OUT_FIFO_IRQ_EN adds IRQ_THRESHOLD and irq_o.
// Ports:
//   wb_clk_i, wb_rst_i           clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i/sel_i   Wishbone request
//   wbs_adr_i/dat_i              byte address, write data
//   wbs_ack_o/dat_o              single-cycle ack, registered read data
//   external_spike_data_i        vector from the core
//   external_write_en_i          one-cycle push strobe
//   irq_o                        (optional) registered interrupt level
module neuron_spike_out_fifo
    import neuron_spike_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 8,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_8000
`ifdef SPIKE_OUT_FIFO_IRQ_EN
    ,
    parameter int unsigned IRQ_THRESHOLD = 1
`endif
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    input  logic [32*NUM_WORDS-1:0] external_spike_data_i,
    input  logic                    external_write_en_i
`ifdef SPIKE_OUT_FIFO_IRQ_EN
    ,
    output logic                    irq_o
`endif
);

    localparam int unsigned WIDTH = 32 * NUM_WORDS;

    logic [8:0]       off;
    logic             hit, req, data_hit, ctrl_wr;
    ctrl_cmd_t        cmd;
    logic [31:0]      head_word, status_word, rdata;
    logic             ack_q;
    logic [31:0]      dat_q, dat_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;
    logic             irq_bit;

    logic [WIDTH-1:0] fifo_head;
    logic [7:0]       fifo_count;
    logic             fifo_empty, fifo_full, fifo_drop;

    // Byte lanes and upper data bits beyond CTRL[2:0] carry no meaning here
    logic unused_wb;
    assign unused_wb = ^{wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:3]};

    // Request decode; ack_q blocks re-triggering so held requests ack every other cycle
    always_comb begin
        off      = wbs_adr_i[8:0];
        hit      = (wbs_adr_i[31:9] == BASE_ADDR[31:9]);
        req      = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
        data_hit = ((off & 9'h100) == DATA_OFS) && ({26'd0, off[7:2]} < NUM_WORDS);
        ctrl_wr  = req & wbs_we_i & (off == CTRL_OFS) & wbs_sel_i[0];

        cmd = '0;
        if (ctrl_wr) begin
            cmd.pop     = wbs_dat_i[POP_BIT];
            cmd.clr_ovf = wbs_dat_i[CLR_OVF_BIT];
            cmd.flush   = wbs_dat_i[FLUSH_BIT];
        end
    end

    spike_vec_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (external_write_en_i),
        .pop_i   (cmd.pop),
        .flush_i (cmd.flush),
        .wdata_i (external_spike_data_i),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .drop_o  (fifo_drop)
    );

    // Head word select
    always_comb begin
        head_word = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (off[7:2] == 6'(i)) head_word = fifo_head[i*32 +: 32];
        end
    end

    always_comb begin
        status_word = pack_status(fifo_count, fifo_empty, fifo_full, ovf_q, drop_q, irq_bit);
        if (data_hit) begin
            rdata = fifo_empty ? 32'd0 : head_word;
        end else if (off == STATUS_OFS) begin
            rdata = status_word;
        end else begin
            rdata = 32'd0;
        end
        dat_d = (req & ~wbs_we_i) ? rdata : 32'd0;
    end

    // Clear is applied first so a same-cycle drop wins and leaves drop_cnt = 1
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (cmd.clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
        if (fifo_drop) begin
            ovf_d = 1'b1;
            if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            ack_q  <= req;
            dat_q  <= dat_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

`ifdef SPIKE_OUT_FIFO_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = (32'(fifo_count) >= IRQ_THRESHOLD) | ovf_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign irq_bit = irq_q;
    assign irq_o   = irq_q;
`else
    assign irq_bit = 1'b0;
`endif

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: doc/neuron_spike_out_fifo.md
Name: neuron_spike_out_fifo

Overview:
Parametrised successor to the single-word spike output register. It buffers DEPTH complete spike vectors, each NUM_WORDS×32 bits, pushed by the neuromorphic core. The RISC-V host reads the head vector word-by-word over a Wishbone slave, then pops it through a control register. The block provides occupancy and status, sticky overflow and a saturating drop counter, so no timestep is silently lost between host polls.

Parameters:
- NUM_WORDS, 8, 32-bit words per spike vector (8 = 256 neurons); legal range 1..64.
- DEPTH, 4, number of FIFO entries (whole vectors); legal range 2..255, power of two not required.
- BASE_ADDR, 32'h3000_8000, Wishbone window base; 512-byte aligned.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; apply to the control register only.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- external_spike_data_i  in  32*NUM_WORDS  spike vector from core; word i occupies bits [32i+31:32i].
- external_write_en_i  in  1  one-cycle push strobe.

Behaviour:
- Reset (async, high): FIFO empty; rd/wr pointers and count 0; overflow 0; drop_cnt 0; wbs_ack_o 0; wbs_dat_o 0.
- Window decode: hit when wbs_adr_i[31:9] == BASE_ADDR[31:9]. Offset off = wbs_adr_i[8:0].
- Address map:
  - Offsets 0x000..4*(NUM_WORDS-1): DATA. Read-only, returns word off[7:2] of the head entry. Returns 0 when the FIFO is empty.
  - Offset 0x100: STATUS, read-only.
    - [7:0] count.
    - [8] empty.
    - [9] full.
    - [10] overflow (sticky).
    - [23:16] drop_cnt.
    - All other bits 0.
  - Offset 0x104: CTRL, write-only, reads 0. Bits are acted on only if wbs_sel_i[0]=1.
    - bit0 POP.
    - bit1 CLR_OVF: clears overflow and drop_cnt.
    - bit2 FLUSH.
  - Other offsets inside the window: reads return 0, writes are ignored, still acked.
- Handshake:
  - A request (cyc & stb & hit & !ack) sets wbs_ack_o on the next posedge, for exactly one cycle.
  - wbs_dat_o is registered in that same edge.
  - Back-to-back requests ack on alternate cycles.
  - Non-hit requests are never acked.
- CTRL side effects occur on the same edge that asserts ack. Effects are single-shot per transaction.
- Push: on external_write_en_i=1, the full vector is written at wr_ptr. wr_ptr wraps DEPTH-1 → 0; count increments.
- Push while full, with no pop in the same cycle:
  - Vector is dropped and FIFO contents are unchanged.
  - overflow set to 1.
  - drop_cnt increments, saturating at 255.
- Pop: rd_ptr advances (wraps) and count decrements. Pop while empty is ignored with no flag.
- Simultaneous push and pop: both take effect and count is unchanged.
  - When full, no overflow is raised.
  - When empty, the pop is ignored and the push proceeds, so count becomes 1.
- FLUSH: pointers and count go to 0 and take priority over any same-cycle push or pop. A same-cycle push is discarded and is not counted as a drop. overflow and drop_cnt are preserved.
- CLR_OVF together with a same-cycle overflowing push: the set wins, leaving overflow=1 and drop_cnt=1.
- Read data reflects state before the edge. A read of DATA in the same cycle as a core push to an empty FIFO returns 0.
- Asserting reset mid-transaction aborts it with no ack; all state returns to reset values.
- Latency: a pushed vector is visible to a DATA read issued on the cycle after the push edge.

Optional Feature:
- Macro SPIKE_OUT_FIFO_IRQ_EN.
- Defined:
  - Adds parameter IRQ_THRESHOLD (default 1) and output irq_o (1 bit, reset 0).
  - irq_o is a registered level: (count >= IRQ_THRESHOLD) | overflow.
  - STATUS[31] mirrors irq_o.
- Undefined: no irq_o port, no IRQ_THRESHOLD parameter, and STATUS[31] reads 0.

Decomposition:
- Package neuron_spike_pkg holds:
  - Offsets DATA_OFS=9'h000, STATUS_OFS=9'h100, CTRL_OFS=9'h104.
  - CTRL bit indices POP_BIT=0, CLR_OVF_BIT=1, FLUSH_BIT=2.
  - STATUS bit positions.
- Sub-module spike_vec_fifo: storage array, pointers, count, full/empty, push/pop/flush priority. Its parameters are WIDTH=32*NUM_WORDS and DEPTH, and it exposes the head vector combinationally.
- Top level: Wishbone decode, ack, and read mux; overflow and drop_cnt; optional IRQ.

Test Plan:
- After reset, read 0x3000_8100 → 0x0000_0100 (empty=1); read 0x3000_8000 → 0.
- Push vectors V0 (word i = 32'hA000_0000+i) and V1 → STATUS count=2. Read 0x3000_801C → 32'hA000_0007. Write CTRL=1 (pop), read 0x3000_8000 → V1 word 0 and count=1.
- Push 5 vectors at DEPTH=4 → count=4, full=1, overflow=1, drop_cnt=1. After 4 pops the values read are the first 4 vectors in order. Write CTRL=2 → STATUS = 0x0000_0100.
- With full FIFO, pulse external_write_en_i on the same edge as the CTRL pop ack → count stays 4, overflow stays 0. The newest vector is read after 3 further pops; pointer wrap is exercised.
- Write CTRL=4 concurrent with a push → count=0, drop_cnt unchanged. A write to DATA offset 0 and a read of 0x3000_8180 are both acked with no state change; the read returns 0.
- With SPIKE_OUT_FIFO_IRQ_EN and IRQ_THRESHOLD=2: one push → irq_o=0; second push → irq_o=1 one cycle later; one pop → irq_o=0.
